// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for the counter stream and its checker: state codes and
// the default run bounds both sides agree on.
package count_defs;
  localparam int CNT_W     = 8;
  localparam int START_DEF = 5;
  localparam int STOP_DEF  = 67;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/count_seq_checker_if.sv
// Valid-qualified counter stream between a producer (master) and a checker (slave).
interface count_seq_checker_if
  import count_defs::*;
#(
  parameter int WIDTH = CNT_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with inc loads 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end
endmodule

// File: rtl/count_seq_checker.sv
// Checks that a valid-qualified stream is a gap-free run START..STOP, holding at STOP,
// and reports completion, sticky error, saturating error count and run length.
module count_seq_checker
  import count_defs::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int START = START_DEF,
  parameter int STOP  = STOP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  count_seq_checker_if.slave   s,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           err_cnt,
  output logic [WIDTH-1:0]     expected,
  output logic [15:0]          run_len,
  output logic [WIDTH-1:0]     first_bad
);
  generate
    if ((START > STOP) || (START < 0) || (longint'(STOP) >= (longint'(1) << WIDTH))) begin : g_bad_params
      $fatal(1, "count_seq_checker: illegal START=%0d STOP=%0d for WIDTH=%0d", START, STOP, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] STOP_V  = WIDTH'(STOP);
  localparam logic [WIDTH-1:0] NEXT_V  = WIDTH'(START + 1);
  localparam bit               SINGLE  = (START == STOP);

  state_t state;
  logic   is_start, is_stop, is_exp;
  logic   run_clr, run_inc, err_inc;

  // If-based compares so an X/Z sample falls through as "no match".
  always_comb begin
    is_start = 1'b0;
    is_stop  = 1'b0;
    is_exp   = 1'b0;
    if (s.in_data == START_V)  is_start = 1'b1;
    if (s.in_data == STOP_V)   is_stop  = 1'b1;
    if (s.in_data == expected) is_exp   = 1'b1;
  end

  always_comb begin
    run_clr = 1'b0;
    run_inc = 1'b0;
    err_inc = 1'b0;
    if (s.in_valid) begin
      case (state)
        IDLE: begin
          if (is_start) begin
            run_clr = 1'b1;
            run_inc = 1'b1;
          end
        end
        RUN: begin
          if (is_exp) begin
            run_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
            run_clr = 1'b1;
            run_inc = is_start;
          end
        end
        DONE: begin
          if (!is_stop) begin
            if (is_start) begin
              run_clr = 1'b1;
              run_inc = 1'b1;
            end else begin
              err_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      error     <= 1'b0;
      first_bad <= '0;
      expected  <= START_V;
    end else begin
      case (state)
        IDLE: begin
          if (s.in_valid && is_start) begin
            if (SINGLE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              expected <= NEXT_V;
            end
          end
        end
        RUN: begin
          if (s.in_valid) begin
            if (is_exp) begin
              if (is_stop) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                expected <= expected + WIDTH'(1);
              end
            end else begin
              error <= 1'b1;
              if (!error) first_bad <= s.in_data;
              if (is_start) begin
                expected <= NEXT_V;
              end else begin
                state    <= IDLE;
                expected <= START_V;
              end
            end
          end
        end
        DONE: begin
          if (s.in_valid && !is_stop) begin
            if (is_start) begin
              state    <= RUN;
              done     <= 1'b0;
              expected <= NEXT_V;
            end else begin
              error <= 1'b1;
              if (!error) first_bad <= s.in_data;
            end
          end
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          expected <= START_V;
        end
      endcase
    end
  end

  sat_counter #(.W(8)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (err_inc),
    .q   (err_cnt)
  );

  sat_counter #(.W(16)) u_run_len (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (run_inc),
    .q   (run_len)
  );
endmodule
